// File: rtl/chess_pkg.sv
// -----------------------------------------------------------------------------
// chess_pkg
// Shared definitions for the board evaluator:
//   - signed 8-bit piece codes (white positive, black negative, EMPTY = 0)
//   - code-magnitude range bounds and centipawn piece values
//   - slave register addresses
//   - evaluator FSM state enum
//   - initial best-score helper
// -----------------------------------------------------------------------------
package chess_pkg;

    // Piece codes. Each piece type owns a band of magnitudes so that
    // individual pieces can carry distinct codes.
    localparam logic signed [7:0] EMPTY    = 8'sd0;
    localparam logic signed [7:0] WPAWN0   = 8'sd1;
    localparam logic signed [7:0] WPAWN1   = 8'sd2;
    localparam logic signed [7:0] WPAWN2   = 8'sd3;
    localparam logic signed [7:0] WPAWN3   = 8'sd4;
    localparam logic signed [7:0] WPAWN4   = 8'sd5;
    localparam logic signed [7:0] WPAWN5   = 8'sd6;
    localparam logic signed [7:0] WPAWN6   = 8'sd7;
    localparam logic signed [7:0] WPAWN7   = 8'sd8;
    localparam logic signed [7:0] WROOK0   = 8'sd9;
    localparam logic signed [7:0] WROOK1   = 8'sd10;
    localparam logic signed [7:0] WKNIGHT0 = 8'sd19;
    localparam logic signed [7:0] WKNIGHT1 = 8'sd20;
    localparam logic signed [7:0] WBISHOP0 = 8'sd29;
    localparam logic signed [7:0] WBISHOP1 = 8'sd30;
    localparam logic signed [7:0] WQUEEN   = 8'sd39;
    localparam logic signed [7:0] WKING    = 8'sd48;
    localparam logic signed [7:0] BPAWN0   = -8'sd1;
    localparam logic signed [7:0] BPAWN1   = -8'sd2;
    localparam logic signed [7:0] BPAWN2   = -8'sd3;
    localparam logic signed [7:0] BPAWN3   = -8'sd4;
    localparam logic signed [7:0] BPAWN4   = -8'sd5;
    localparam logic signed [7:0] BPAWN5   = -8'sd6;
    localparam logic signed [7:0] BPAWN6   = -8'sd7;
    localparam logic signed [7:0] BPAWN7   = -8'sd8;
    localparam logic signed [7:0] BROOK0   = -8'sd9;
    localparam logic signed [7:0] BROOK1   = -8'sd10;
    localparam logic signed [7:0] BKNIGHT0 = -8'sd19;
    localparam logic signed [7:0] BKNIGHT1 = -8'sd20;
    localparam logic signed [7:0] BBISHOP0 = -8'sd29;
    localparam logic signed [7:0] BBISHOP1 = -8'sd30;
    localparam logic signed [7:0] BQUEEN   = -8'sd39;
    localparam logic signed [7:0] BKING    = -8'sd48;

    // Upper magnitude bound of each piece band (lower bound is previous + 1).
    localparam logic [7:0] PAWN_MAG_MAX   = 8'd8;
    localparam logic [7:0] ROOK_MAG_MAX   = 8'd18;
    localparam logic [7:0] KNIGHT_MAG_MAX = 8'd28;
    localparam logic [7:0] BISHOP_MAG_MAX = 8'd38;
    localparam logic [7:0] QUEEN_MAG_MAX  = 8'd47;
    localparam logic [7:0] KING_MAG       = 8'd48;

    // Piece values (white perspective).
    localparam logic signed [31:0] PAWN_VAL   = 32'sd100;
    localparam logic signed [31:0] ROOK_VAL   = 32'sd500;
    localparam logic signed [31:0] KNIGHT_VAL = 32'sd320;
    localparam logic signed [31:0] BISHOP_VAL = 32'sd330;
    localparam logic signed [31:0] QUEEN_VAL  = 32'sd900;
    localparam logic signed [31:0] KING_VAL   = 32'sd20000;

    // Slave register addresses.
    localparam logic [3:0] REG_CTRL  = 4'd0;
    localparam logic [3:0] REG_SRC   = 4'd1;
    localparam logic [3:0] REG_COUNT = 4'd2;
    localparam logic [3:0] REG_DST   = 4'd3;
    localparam logic [3:0] REG_SIDE  = 4'd4;
    localparam logic [3:0] REG_BEST  = 4'd5;

    // Starting best score: the worst possible value for the side to move.
    localparam logic signed [31:0] BEST_INIT_WHITE = 32'sh8000_0000;
    localparam logic signed [31:0] BEST_INIT_BLACK = 32'sh7FFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_SCORE,
        NEXT,
        DONE
    } state_t;

    function automatic logic signed [31:0] best_init(input logic side_black);
        return side_black ? BEST_INIT_BLACK : BEST_INIT_WHITE;
    endfunction

endpackage

// File: rtl/board_eval_piece_value.sv
// -----------------------------------------------------------------------------
// piece_value
// Combinational map from a signed 8-bit piece code to its signed 32-bit
// material value: magnitude selects the piece band, sign selects the colour.
//   code  : input  signed [7:0]  piece code
//   value : output signed [31:0] material value (negative for black)
// -----------------------------------------------------------------------------
module piece_value
    import chess_pkg::*;
(
    input  logic signed [7:0]  code,
    output logic signed [31:0] value
);

    logic [7:0]         raw;
    logic [7:0]         mag;
    logic signed [31:0] base;

    always_comb begin
        raw = code;
        // -128 has magnitude 128, which falls in the zero-value band.
        mag = raw[7] ? (8'd0 - raw) : raw;

        if (mag == 8'd0)                 base = '0;
        else if (mag <= PAWN_MAG_MAX)    base = PAWN_VAL;
        else if (mag <= ROOK_MAG_MAX)    base = ROOK_VAL;
        else if (mag <= KNIGHT_MAG_MAX)  base = KNIGHT_VAL;
        else if (mag <= BISHOP_MAG_MAX)  base = BISHOP_VAL;
        else if (mag <= QUEEN_MAG_MAX)   base = QUEEN_VAL;
        else if (mag == KING_MAG)        base = KING_VAL;
        else                             base = '0;

        value = raw[7] ? -base : base;
    end

endmodule

// File: rtl/board_eval.sv
// -----------------------------------------------------------------------------
// board_eval
// Material evaluator for a batch of chess boards held in memory. Software
// programs SRC/COUNT/DST/SIDE over the Avalon-MM slave and writes START; the
// Avalon-MM master then reads each board one byte-square at a time, writes
// the board's score to DST+4*i, and tracks the best board for SIDE.
//   clk, rst_n      : clock, asynchronous active-low reset
//   slave_*         : register access (reg0 read stalls until the batch ends)
//   master_*        : board reads / score writes, one transfer at a time
// -----------------------------------------------------------------------------
module board_eval
    import chess_pkg::*;
#(
    parameter int MAX_BOARDS = 255
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    localparam logic [7:0] MAX_COUNT = (MAX_BOARDS > 255) ? 8'd255 : 8'(MAX_BOARDS);

    state_t             state, state_nxt;
    logic [31:0]        src_base, dst_base;
    logic [7:0]         count;
    logic               side;
    logic [7:0]         board_idx;
    logic [5:0]         sq_idx;
    logic signed [31:0] acc;
    logic signed [31:0] best_score;
    logic [31:0]        best_idx;
    logic signed [31:0] sq_value;

    logic cfg_open;
    logic cfg_write;
    logic start;
    logic ctrl_read_done;
    logic more_boards;
    logic unused_readdata;

    function automatic logic [7:0] clamp_count(input logic [7:0] raw);
        return (raw > MAX_COUNT) ? MAX_COUNT : raw;
    endfunction

    // Strict comparison so that equal scores keep the earlier board.
    function automatic logic is_better(input logic side_black,
                                       input logic signed [31:0] score,
                                       input logic signed [31:0] best);
        return side_black ? (score < best) : (score > best);
    endfunction

    piece_value u_piece_value (
        .code  (master_readdata[7:0]),
        .value (sq_value)
    );

    assign unused_readdata = ^master_readdata[31:8];

    // Configuration is only accepted while no batch is running.
    assign cfg_open       = (state == IDLE) || (state == DONE);
    assign cfg_write      = slave_write && cfg_open;
    assign start          = cfg_write && (slave_address == REG_CTRL);
    assign ctrl_read_done = slave_read && (slave_address == REG_CTRL) && (state == DONE);
    assign more_boards    = ({1'b0, board_idx} + 9'd1) < {1'b0, count};

    assign slave_waitrequest = slave_read && (slave_address == REG_CTRL) && !cfg_open;

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                REG_CTRL:  slave_readdata = best_idx;
                REG_SRC:   slave_readdata = src_base;
                REG_COUNT: slave_readdata = {24'd0, count};
                REG_DST:   slave_readdata = dst_base;
                REG_SIDE:  slave_readdata = {31'd0, side};
                REG_BEST:  slave_readdata = best_score;
                default:   slave_readdata = '0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and master outputs; outputs depend only on registered state
    // so they stay stable for the whole of a stalled transfer.
    always_comb begin
        state_nxt        = state;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (count == 8'd0) ? DONE : RD_REQ;
            end
            RD_REQ: begin
                master_read    = 1'b1;
                master_address = src_base + {18'd0, board_idx, sq_idx};
                if (!master_waitrequest) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (master_readdatavalid) state_nxt = (sq_idx == 6'd63) ? WR_SCORE : RD_REQ;
            end
            WR_SCORE: begin
                master_write     = 1'b1;
                master_address   = dst_base + {22'd0, board_idx, 2'b00};
                master_writedata = acc;
                if (!master_waitrequest) state_nxt = NEXT;
            end
            NEXT: begin
                state_nxt = more_boards ? RD_REQ : DONE;
            end
            DONE: begin
                if (start)               state_nxt = (count == 8'd0) ? DONE : RD_REQ;
                else if (ctrl_read_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_base <= '0;
            count    <= '0;
            dst_base <= '0;
            side     <= 1'b0;
        end else if (cfg_write) begin
            case (slave_address)
                REG_SRC:   src_base <= slave_writedata;
                REG_COUNT: count    <= clamp_count(slave_writedata[7:0]);
                REG_DST:   dst_base <= slave_writedata;
                REG_SIDE:  side     <= slave_writedata[0];
                default:   ;
            endcase
        end
    end

    // Walk counters, score accumulator and best tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_idx  <= '0;
            sq_idx     <= '0;
            acc        <= '0;
            best_score <= '0;
            best_idx   <= '0;
        end else if (start) begin
            board_idx  <= '0;
            sq_idx     <= '0;
            acc        <= '0;
            best_score <= best_init(side);
            best_idx   <= '1;
        end else if (state == RD_WAIT && master_readdatavalid) begin
            acc    <= acc + sq_value;
            sq_idx <= sq_idx + 6'd1;
        end else if (state == NEXT) begin
            if (is_better(side, acc, best_score)) begin
                best_score <= acc;
                best_idx   <= {24'd0, board_idx};
            end
            board_idx <= board_idx + 8'd1;
            acc       <= '0;
        end
    end

endmodule
